// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges a priority ALU result with a FIFO-buffered load stream onto the
// register file write port, dropping x0 writes and stalling the ALU to stop load starvation.
// Optional read-port forwarding is enabled with `define RF_WB_FWD_EN.
module rf_wb_arbiter #(
    parameter int unsigned LD_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
`ifdef RF_WB_FWD_EN
    input  logic [4:0]  fwd_a1,
    input  logic [4:0]  fwd_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic [31:0] fwd_rd1,
    output logic [31:0] fwd_rd2,
`endif
    output logic [4:0]  A3,
    output logic [31:0] wd3,
    output logic        we,
    output logic [31:0] wr_cnt
);

    localparam int unsigned AW = $clog2(LD_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_ent_t;

    ld_ent_t          mem [LD_DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;

    logic             empty_c, alu_win_c, pop_c, push_c, stall_nxt_c;
    logic [SW-1:0]    starve_nxt_c;

    assign empty_c   = (count == '0);
    assign ld_ready  = !rst && (count < CW'(LD_DEPTH));
    assign alu_win_c = !alu_stall && alu_valid && (alu_rd != 5'd0);
    assign pop_c     = !alu_win_c && !empty_c;
    assign push_c    = ld_valid && ld_ready && (ld_rd != 5'd0);

    // Starvation tracking: each ALU win over a waiting load counts; a pop clears it.
    always_comb begin
        starve_nxt_c = starve;
        stall_nxt_c  = 1'b0;
        if (alu_win_c && !empty_c) begin
            starve_nxt_c = starve + SW'(1);
            stall_nxt_c  = (starve_nxt_c == SW'(STARVE_MAX));
        end else if (pop_c) begin
            starve_nxt_c = '0;
        end
    end

    // Payload storage needs no reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            starve    <= '0;
            alu_stall <= 1'b0;
            we        <= 1'b0;
            A3        <= 5'd0;
            wd3       <= 32'd0;
            wr_cnt    <= 32'd0;
        end else begin
            if (push_c) wptr <= wptr + AW'(1);
            if (pop_c)  rptr <= rptr + AW'(1);
            count     <= count + CW'(push_c) - CW'(pop_c);
            starve    <= starve_nxt_c;
            alu_stall <= stall_nxt_c;
            we        <= alu_win_c || pop_c;
            if (alu_win_c) begin
                A3  <= alu_rd;
                wd3 <= alu_data;
            end else if (pop_c) begin
                A3  <= mem[rptr].rd;
                wd3 <= mem[rptr].data;
            end
            if (alu_win_c || pop_c) wr_cnt <= wr_cnt + 32'd1;
        end
    end

`ifdef RF_WB_FWD_EN
    // Write-through of the write currently presented to the register file.
    assign fwd_rd1 = (we && (A3 == fwd_a1) && (fwd_a1 != 5'd0)) ? wd3 : rf_rd1;
    assign fwd_rd2 = (we && (A3 == fwd_a2) && (fwd_a2 != 5'd0)) ? wd3 : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based reference model predicts every register
// file write; a separate monitor pops and compares whenever the DUT raises we.
module tb_rf_wb_arbiter;

    localparam int unsigned LD_DEPTH   = 4;
    localparam int unsigned STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  A3;
    logic [31:0] wd3;
    logic        we;
    logic [31:0] wr_cnt;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_a1, fwd_a2;
    logic [31:0] rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

    rf_wb_arbiter #(.LD_DEPTH(LD_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
`ifdef RF_WB_FWD_EN
        .fwd_a1(fwd_a1), .fwd_a2(fwd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
`endif
        .A3(A3), .wd3(wd3), .we(we), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: pending loads, expected writes, and architectural counters.
    logic [36:0] mq  [$];
    logic [36:0] sbq [$];
    int          m_starve = 0;
    bit          m_stall  = 0;
    bit          m_we     = 0;
    logic [31:0] m_cnt    = 0;
    logic [4:0]  m_a3     = 0;
    logic [31:0] m_wd3    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        sbq.delete();
        m_starve = 0;
        m_stall  = 0;
        m_we     = 0;
        m_cnt    = 0;
        m_a3     = 0;
        m_wd3    = 0;
    endtask

    task automatic drive_idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
`ifdef RF_WB_FWD_EN
        fwd_a1 = 0; fwd_a2 = 0; rf_rd1 = 0; rf_rd2 = 0;
`endif
    endtask

    // One clock of stimulus: check visible state, apply inputs, predict the next edge.
    task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ldd);
        bit alu_w, had, rdy, new_stall;
        @(negedge clk);
        chk("ld_ready", 64'(ld_ready), 64'(mq.size() < LD_DEPTH));
        chk("alu_stall", 64'(alu_stall), 64'(m_stall));
        chk("we", 64'(we), 64'(m_we));
        chk("wr_cnt", 64'(wr_cnt), 64'(m_cnt));
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
`ifdef RF_WB_FWD_EN
        fwd_a1 = ($urandom_range(0, 1) == 0) ? m_a3 : 5'($urandom_range(0, 31));
        fwd_a2 = ($urandom_range(0, 3) == 0) ? 5'd0 : m_a3;
        rf_rd1 = $urandom;
        rf_rd2 = $urandom;
        #1;
        chk("fwd_rd1", 64'(fwd_rd1), 64'((m_we && m_a3 == fwd_a1 && fwd_a1 != 0) ? m_wd3 : rf_rd1));
        chk("fwd_rd2", 64'(fwd_rd2), 64'((m_we && m_a3 == fwd_a2 && fwd_a2 != 0) ? m_wd3 : rf_rd2));
`endif
        alu_w     = !m_stall && av && (ar != 0);
        had       = mq.size() != 0;
        rdy       = mq.size() < LD_DEPTH;
        new_stall = 0;
        m_we      = 0;
        if (alu_w) begin
            sbq.push_back({ar, ad});
            m_we = 1;
            {m_a3, m_wd3} = {ar, ad};
            if (had) begin
                m_starve++;
                new_stall = (m_starve == STARVE_MAX);
            end
        end else if (had) begin
            {m_a3, m_wd3} = mq.pop_front();
            sbq.push_back({m_a3, m_wd3});
            m_we = 1;
            m_starve = 0;
        end
        if (lv && rdy && lr != 0) mq.push_back({lr, ldd});
        if (m_we) m_cnt = m_cnt + 1;
        m_stall = new_stall;
    endtask

    // Asynchronous reset in the middle of a cycle, then release at the next falling edge.
    task automatic mid_reset();
        @(negedge clk);
        drive_idle();
        #2 rst = 1;
        #1;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("rst_alu_stall", 64'(alu_stall), 64'd0);
        chk("rst_a3_wd3", 64'({A3, wd3}), 64'd0);
        @(negedge clk);
        model_reset();
        rst = 0;
        #1 chk("post_rst_ld_ready", 64'(ld_ready), 64'd1);
    endtask

    // Monitor: every DUT write must match the oldest predicted write.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (sbq.size() == 0) chk("unexpected_write", 64'({A3, wd3}), 64'h1_0000_0000_0);
            else chk("write_a3_wd3", 64'({A3, wd3}), 64'(sbq.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bit          pav, plv;
        logic [4:0]  par, plr;
        logic [31:0] pad, pld;
        rst = 1;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("init_ld_ready", 64'(ld_ready), 64'd0);
        chk("init_outputs", 64'({we, alu_stall, A3, wd3}), 64'd0);
        rst = 0;
        #1 chk("init_wr_cnt", 64'(wr_cnt), 64'd0);

        // Single load on an idle bus: written two edges after acceptance.
        cycle(0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);

        // ALU priority with one competing load; starvation stall lets the load through.
        cycle(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'h12345678);
        repeat (6) cycle(1, 5'd5, 32'hAAAA0001, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // x0 writes from both sources are dropped.
        cycle(1, 5'd0, 32'h1111, 1, 5'd0, 32'h2222);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Fill the FIFO under continuous ALU traffic, then drain.
        for (int i = 0; i < 8; i++)
            cycle(1, 5'd3, 32'hA000_0000 + 32'(i), 1, 5'(10 + i), 32'hB000_0000 + 32'(i));
        repeat (8) cycle(0, 0, 0, 0, 0, 0);

        // Reset while three loads are buffered.
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd4, 32'hC0DE_0000 + 32'(i), 1, 5'(20 + i), 32'hD000_0000 + 32'(i));
        mid_reset();
        repeat (6) cycle(0, 0, 0, 0, 0, 0);

        // Randomized traffic; the ALU holds its result while stalled, loads hold until accepted.
        pav = 0; par = 0; pad = 0; plv = 0; plr = 0; pld = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!(m_stall && pav)) begin
                pav = ($urandom_range(0, 99) < 65);
                par = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pad = $urandom;
            end
            if (!(plv && mq.size() >= LD_DEPTH)) begin
                plv = ($urandom_range(0, 1) == 1);
                plr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pld = $urandom;
            end
            cycle(pav, par, pad, plv, plr, pld);
            if (i == 1000) mid_reset();
        end
        repeat (12) cycle(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        chk("fifo_drained", 64'(mq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
